// File: rtl/maze_ctrl_if.sv
// Handshake bundle between maze_ctrl and the maze-walker datapath, maze memory and top level.
// The master modport is the controller's view; the slave modport is the environment's view.
interface maze_ctrl_if;
  logic       start;
  logic       cntReach;
  logic       empStck;
  logic [7:0] curLoc;
  logic [7:0] nxtLoc;
  logic       memData;
  logic       dpRst;
  logic       rgLd;
  logic [1:0] dir;
  logic       push;
  logic       pop;
  logic       adderEn;
  logic [7:0] memAdr;
  logic       memRd;
  logic       memWr;
  logic       busy;
  logic       done;
  logic       fail;

  modport master (
    input  start, cntReach, empStck, curLoc, nxtLoc, memData,
    output dpRst, rgLd, dir, push, pop, adderEn, memAdr, memRd, memWr, busy, done, fail
  );

  modport slave (
    output start, cntReach, empStck, curLoc, nxtLoc, memData,
    input  dpRst, rgLd, dir, push, pop, adderEn, memAdr, memRd, memWr, busy, done, fail
  );
endinterface

// File: rtl/maze_ctrl.sv
// Depth-first-search control FSM for the maze walker: sequences the datapath and the
// maze-memory handshake from location 8'h00 to GOAL_LOC, reporting done or fail.
module maze_ctrl #(
  parameter logic [7:0]  GOAL_LOC  = 8'hFF,
  parameter int unsigned MAX_STEPS = 1023
) (
  input logic         clk,
  input logic         rst,
  maze_ctrl_if.master bus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_INIT  = 4'd1;
  localparam logic [3:0] S_MARK  = 4'd2;
  localparam logic [3:0] S_TRY   = 4'd3;
  localparam logic [3:0] S_CHECK = 4'd4;
  localparam logic [3:0] S_MOVE  = 4'd5;
  localparam logic [3:0] S_NEXT  = 4'd6;
  localparam logic [3:0] S_BACK  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [3:0] S_FAIL  = 4'd9;

  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);

  logic [3:0]  r_state;
  logic [3:0]  w_nextState;
  logic [1:0]  r_dir;
  logic [1:0]  w_nextDir;
  logic [15:0] r_stepCnt;
  logic [15:0] w_nextCnt;
  logic [15:0] w_cntPlus;
  logic        r_startSeenLow;
  logic        w_nextSeenLow;
  logic        w_atGoal;
  logic        w_hitLimit;
  logic        w_terminal;

  logic w_dpRst;
  logic w_rgLd;
  logic w_push;
  logic w_pop;
  logic w_adderEn;
  logic w_memRd;
  logic w_memWr;

  assign w_atGoal   = (bus.curLoc == GOAL_LOC);
  assign w_terminal = (r_state == S_DONE) || (r_state == S_FAIL);
  assign w_cntPlus  = (r_stepCnt >= STEP_LIMIT) ? r_stepCnt : r_stepCnt + 16'd1;
  assign w_hitLimit = (w_cntPlus >= STEP_LIMIT);

  // A new search from DONE/FAIL needs start to be seen low first, so a held start cannot re-trigger.
  assign w_nextSeenLow = w_terminal && (r_startSeenLow || !bus.start);

  always_comb begin
    w_nextState = r_state;
    w_nextDir   = r_dir;
    w_nextCnt   = r_stepCnt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_nextState = S_INIT;
      end
      S_INIT: begin
        w_nextDir   = 2'b00;
        w_nextCnt   = 16'd0;
        w_nextState = S_MARK;
      end
      S_MARK: begin
        w_nextState = S_TRY;
      end
      S_TRY: begin
        if (w_atGoal)          w_nextState = S_DONE;
        else if (bus.cntReach) w_nextState = S_NEXT;
        else                   w_nextState = S_CHECK;
      end
      S_CHECK: begin
        w_nextState = bus.memData ? S_NEXT : S_MOVE;
      end
      S_MOVE, S_BACK: begin
        w_nextCnt   = w_cntPlus;
        w_nextDir   = 2'b00;
        w_nextState = w_hitLimit ? S_FAIL : S_TRY;
      end
      S_NEXT: begin
        if (r_dir != 2'b11) begin
          w_nextDir   = r_dir + 2'd1;
          w_nextState = S_TRY;
        end else if (bus.empStck) begin
          w_nextState = S_FAIL;
        end else begin
          w_nextState = S_BACK;
        end
      end
      S_DONE, S_FAIL: begin
        if (bus.start && r_startSeenLow) w_nextState = S_INIT;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_dpRst   = 1'b0;
    w_rgLd    = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_adderEn = 1'b0;
    w_memRd   = 1'b0;
    w_memWr   = 1'b0;
    case (r_state)
      S_INIT:  w_dpRst = 1'b1;
      S_MARK:  w_memWr = 1'b1;
      S_TRY: begin
        if (!w_atGoal && !bus.cntReach) begin
          w_adderEn = 1'b1;
          w_memRd   = 1'b1;
        end
      end
      S_CHECK: w_adderEn = 1'b1;
      S_MOVE: begin
        w_adderEn = 1'b1;
        w_push    = 1'b1;
        w_rgLd    = 1'b1;
        w_memWr   = 1'b1;
      end
      S_BACK: begin
        w_pop  = 1'b1;
        w_rgLd = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_dir          <= 2'b00;
      r_stepCnt      <= 16'd0;
      r_startSeenLow <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_dir          <= w_nextDir;
      r_stepCnt      <= w_nextCnt;
      r_startSeenLow <= w_nextSeenLow;
    end
  end

  assign bus.dpRst   = w_dpRst;
  assign bus.rgLd    = w_rgLd;
  assign bus.push    = w_push;
  assign bus.pop     = w_pop;
  assign bus.adderEn = w_adderEn;
  assign bus.memRd   = w_memRd;
  assign bus.memWr   = w_memWr;
  assign bus.dir     = r_dir;
  assign bus.memAdr  = bus.nxtLoc;
  assign bus.busy    = (r_state != S_IDLE) && !w_terminal;
  assign bus.done    = (r_state == S_DONE);
  assign bus.fail    = (r_state == S_FAIL);

endmodule

// File: tb/tb_maze_ctrl.sv
// Directed bench for maze_ctrl: three instances (default, MAX_STEPS=4, GOAL_LOC=0), each
// driving a behavioural datapath, location stack and maze memory with bench-owned walls.
module tb_maze_ctrl;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] startV = '0;
  logic [N-1:0] doneV;
  logic [N-1:0] failV;
  logic         walls [N][256];
  int           checks = 0;
  int           failures = 0;
  int           waitCnt;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gInst
    maze_ctrl_if bus ();

    maze_ctrl #(
      .GOAL_LOC  (g == 2 ? 8'h00 : 8'hFF),
      .MAX_STEPS (g == 1 ? 4 : 1023)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic [3:0] x = 4'd0;
    logic [3:0] y = 4'd0;
    logic [3:0] sx;
    logic [3:0] sy;
    logic [7:0] stack [256];
    logic [7:0] sp = 8'd0;
    logic       visited [256];
    logic       rdData = 1'b0;
    int         pushCnt = 0;
    int         popCnt = 0;
    int         rgLdCnt = 0;
    int         wrCnt = 0;
    int         adderCnt = 0;
    int         exclViol = 0;
    logic [7:0] wrLog [8];
    logic [7:0] ldLog [8];

    always_comb begin
      sx = x;
      sy = y;
      case (bus.dir)
        2'b00:   sy = y - 4'd1;
        2'b01:   sx = x + 4'd1;
        2'b10:   sx = x - 4'd1;
        default: sy = y + 4'd1;
      endcase
    end

    assign bus.start    = startV[g];
    assign bus.curLoc   = {x, y};
    assign bus.nxtLoc   = bus.pop ? ((sp != 8'd0) ? stack[sp - 8'd1] : 8'h00)
                                  : (bus.adderEn ? {sx, sy} : {x, y});
    assign bus.cntReach = (bus.dir == 2'b00 && y == 4'h0) || (bus.dir == 2'b01 && x == 4'hF) ||
                          (bus.dir == 2'b10 && x == 4'h0) || (bus.dir == 2'b11 && y == 4'hF);
    assign bus.empStck  = (sp == 8'd0);
    assign bus.memData  = rdData;
    assign doneV[g]     = bus.done;
    assign failV[g]     = bus.fail;

    // Datapath, stack and maze memory model; the visited map is cleared with the datapath.
    always @(posedge clk) begin
      if (bus.dpRst) begin
        x <= 4'd0;
        y <= 4'd0;
        sp <= 8'd0;
        rdData <= 1'b0;
        pushCnt <= 0;
        popCnt <= 0;
        rgLdCnt <= 0;
        wrCnt <= 0;
        adderCnt <= 0;
        exclViol <= 0;
        for (int i = 0; i < 256; i++) visited[i] <= 1'b0;
      end else begin
        if (bus.memRd) rdData <= walls[g][bus.memAdr] | visited[bus.memAdr];
        if (bus.memWr) begin
          visited[bus.memAdr] <= 1'b1;
          if (wrCnt < 8) wrLog[wrCnt[2:0]] <= bus.memAdr;
          wrCnt <= wrCnt + 1;
        end
        if (bus.rgLd) begin
          {x, y} <= bus.nxtLoc;
          if (rgLdCnt < 8) ldLog[rgLdCnt[2:0]] <= bus.nxtLoc;
          rgLdCnt <= rgLdCnt + 1;
        end
        if (bus.push) begin
          stack[sp] <= {x, y};
          sp <= sp + 8'd1;
          pushCnt <= pushCnt + 1;
        end
        if (bus.pop) begin
          sp <= sp - 8'd1;
          popCnt <= popCnt + 1;
        end
        if (bus.adderEn) adderCnt <= adderCnt + 1;
        if ((bus.push || bus.pop || bus.memWr) && bus.memRd) exclViol <= exclViol + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int g, input logic v);
    startV[g] = v;
    @(negedge clk);
  endtask

  task automatic waitTerm(input int g, input int budget, input string tag);
    int n = 0;
    while (!(doneV[g] || failV[g]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_terminated"}, 32'(doneV[g] | failV[g]), 32'd1);
  endtask

  initial begin
    for (int g = 0; g < N; g++)
      for (int i = 0; i < 256; i++) walls[g][i] = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(gInst[0].bus.busy), 32'd0);
    checkOutput("rst_done_fail", 32'({gInst[0].bus.done, gInst[0].bus.fail}), 32'd0);
    checkOutput("rst_dir", 32'(gInst[0].bus.dir), 32'd0);
    checkOutput("rst_strobes", 32'({gInst[0].bus.dpRst, gInst[0].bus.rgLd, gInst[0].bus.push,
                gInst[0].bus.pop, gInst[0].bus.adderEn, gInst[0].bus.memRd, gInst[0].bus.memWr}), 32'd0);

    $display("[TB] empty maze to 8'hFF");
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b1);
    checkOutput("init_dpRst", 32'(gInst[0].bus.dpRst), 32'd1);
    checkOutput("init_busy", 32'(gInst[0].bus.busy), 32'd1);
    applyStimulus(0, 1'b0);
    checkOutput("mark_memWr", 32'(gInst[0].bus.memWr), 32'd1);
    checkOutput("mark_adr", 32'(gInst[0].bus.memAdr), 32'h00);
    checkOutput("mark_noRd", 32'(gInst[0].bus.memRd), 32'd0);
    @(negedge clk);
    checkOutput("try_edge_strobes", 32'({gInst[0].bus.adderEn, gInst[0].bus.memRd}), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("try_open_rd", 32'({gInst[0].bus.adderEn, gInst[0].bus.memRd}), 32'd3);
    checkOutput("try_open_adr", 32'(gInst[0].bus.memAdr), 32'h10);
    checkOutput("try_open_dir", 32'(gInst[0].bus.dir), 32'd1);
    @(negedge clk);
    checkOutput("check_strobes", 32'({gInst[0].bus.adderEn, gInst[0].bus.memRd}), 32'd2);
    @(negedge clk);
    checkOutput("move_strobes", 32'({gInst[0].bus.push, gInst[0].bus.rgLd, gInst[0].bus.memWr,
                gInst[0].bus.pop}), 32'he);
    checkOutput("move_adr", 32'(gInst[0].bus.memAdr), 32'h10);
    waitTerm(0, 20000, "empty");
    checkOutput("empty_done", 32'({gInst[0].bus.done, gInst[0].bus.fail}), 32'd2);
    // Row-by-row serpentine: 15 rows of 15 moves plus 15 row changes before reaching FF.
    checkOutput("empty_pushes", 32'(gInst[0].pushCnt), 32'd240);
    checkOutput("empty_pops", 32'(gInst[0].popCnt), 32'd0);
    checkOutput("empty_writes", 32'(gInst[0].wrCnt), 32'd241);
    checkOutput("empty_loc", 32'(gInst[0].bus.curLoc), 32'hFF);
    checkOutput("empty_busy", 32'(gInst[0].bus.busy), 32'd0);
    checkOutput("empty_excl", 32'(gInst[0].exclViol), 32'd0);
    @(negedge clk);
    checkOutput("done_strobes", 32'({gInst[0].bus.rgLd, gInst[0].bus.push, gInst[0].bus.pop,
                gInst[0].bus.adderEn, gInst[0].bus.memRd, gInst[0].bus.memWr}), 32'd0);

    $display("[TB] start blocked on both open sides");
    walls[0][8'h10] = 1'b1;
    walls[0][8'h01] = 1'b1;
    applyStimulus(0, 1'b1);
    checkOutput("blk_restart_dpRst", 32'(gInst[0].bus.dpRst), 32'd1);
    waitTerm(0, 200, "blk");
    checkOutput("blk_fail", 32'({gInst[0].bus.done, gInst[0].bus.fail}), 32'd1);
    checkOutput("blk_pushes", 32'(gInst[0].pushCnt), 32'd0);
    checkOutput("blk_rgLd", 32'(gInst[0].rgLdCnt), 32'd0);
    checkOutput("blk_dir", 32'(gInst[0].bus.dir), 32'd3);
    repeat (3) @(negedge clk);
    checkOutput("blk_held_start_ignored", 32'({gInst[0].bus.fail, gInst[0].bus.dpRst}), 32'd2);
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b1);
    checkOutput("blk_relaunch_dpRst", 32'(gInst[0].bus.dpRst), 32'd1);
    waitTerm(0, 200, "blk2");

    $display("[TB] dead-end corridor");
    for (int i = 0; i < 256; i++) walls[0][i] = 1'b0;
    walls[0][8'h30] = 1'b1;
    walls[0][8'h21] = 1'b1;
    walls[0][8'h11] = 1'b1;
    walls[0][8'h01] = 1'b1;
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b1);
    startV[0] = 1'b0;
    waitTerm(0, 500, "dead");
    checkOutput("dead_fail", 32'({gInst[0].bus.done, gInst[0].bus.fail}), 32'd1);
    checkOutput("dead_pushes", 32'(gInst[0].pushCnt), 32'd2);
    checkOutput("dead_pops", 32'(gInst[0].popCnt), 32'd2);
    checkOutput("dead_rgLd", 32'(gInst[0].rgLdCnt), 32'd4);
    checkOutput("dead_writes", 32'(gInst[0].wrCnt), 32'd3);
    checkOutput("dead_wr_adrs", {8'h0, gInst[0].wrLog[0], gInst[0].wrLog[1], gInst[0].wrLog[2]},
                32'h00_00_10_20);
    checkOutput("dead_back_targets", {16'h0, gInst[0].ldLog[2], gInst[0].ldLog[3]}, 32'h1000);
    checkOutput("dead_excl", 32'(gInst[0].exclViol), 32'd0);

    $display("[TB] step limit of 4");
    applyStimulus(1, 1'b1);
    startV[1] = 1'b0;
    waitTerm(1, 200, "limit");
    checkOutput("limit_fail", 32'({gInst[1].bus.done, gInst[1].bus.fail}), 32'd1);
    checkOutput("limit_pushes", 32'(gInst[1].pushCnt), 32'd4);
    checkOutput("limit_loc", 32'(gInst[1].bus.curLoc), 32'h40);
    repeat (5) @(negedge clk);
    checkOutput("limit_no_more_rgLd", 32'(gInst[1].rgLdCnt), 32'd4);

    $display("[TB] reset during CHECK");
    for (int i = 0; i < 256; i++) walls[0][i] = 1'b0;
    applyStimulus(0, 1'b1);
    startV[0] = 1'b0;
    waitCnt = 0;
    while (!gInst[0].bus.memRd && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("rstmid_saw_read", 32'(gInst[0].bus.memRd), 32'd1);
    @(negedge clk);
    checkOutput("rstmid_in_check", 32'({gInst[0].bus.adderEn, gInst[0].bus.memRd, gInst[0].bus.busy}),
                32'd5);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_idle_busy", 32'({gInst[0].bus.busy, gInst[0].bus.done, gInst[0].bus.fail}), 32'd0);
    checkOutput("rstmid_strobes", 32'({gInst[0].bus.dpRst, gInst[0].bus.rgLd, gInst[0].bus.push,
                gInst[0].bus.pop, gInst[0].bus.adderEn, gInst[0].bus.memRd, gInst[0].bus.memWr}), 32'd0);
    checkOutput("rstmid_dir", 32'(gInst[0].bus.dir), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b1);
    checkOutput("rstmid_dpRst", 32'(gInst[0].bus.dpRst), 32'd1);
    startV[0] = 1'b0;
    waitTerm(0, 20000, "rstmid");
    checkOutput("rstmid_done", 32'({gInst[0].bus.done, gInst[0].bus.fail}), 32'd2);
    checkOutput("rstmid_pushes", 32'(gInst[0].pushCnt), 32'd240);

    $display("[TB] goal at origin");
    applyStimulus(2, 1'b1);
    startV[2] = 1'b0;
    checkOutput("goal0_init", 32'(gInst[2].bus.dpRst), 32'd1);
    @(negedge clk);
    checkOutput("goal0_mark", 32'(gInst[2].bus.memWr), 32'd1);
    @(negedge clk);
    checkOutput("goal0_try", 32'({gInst[2].bus.busy, gInst[2].bus.adderEn, gInst[2].bus.memRd}), 32'd4);
    @(negedge clk);
    checkOutput("goal0_done", 32'({gInst[2].bus.done, gInst[2].bus.fail}), 32'd2);
    checkOutput("goal0_no_adder", 32'(gInst[2].adderCnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
